arb_lock_m2s: RTL and testbench



---
 rtl/axi_ic_pkg.sv | 30 +++
 rtl/arb_rr_pick.sv | 54 +++++
 rtl/arb_lock_m2s.sv | 92 +++++++++
 tb/tb_arb_lock_m2s.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared arbitration constants, FSM encoding and helpers
package axi_ic_pkg;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    // Binary index of a one-hot vector (0 for an all-zero vector).
    function automatic int onehot2bin(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational round-robin / fixed-priority winner pick
// Ports:
//   req      per-master request
//   ptr      last winner index; round-robin search starts at ptr+1
//   mode     ARB_RR or ARB_FIXED
//   win      one-hot winner (zero when req is zero)
//   win_idx  binary winner index (zero when req is zero)
module arb_rr_pick
    import axi_ic_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int IDX_W = clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [NUM_M-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    logic [NUM_M-1:0]   mask;
    logic [2*NUM_M-1:0] dbl;
    logic               found;
    int                 pos;

    always_comb begin
        // Lower copy keeps only requests above ptr; the upper unmasked copy
        // provides the wrap-around. Fixed mode opens the mask fully so the
        // lowest request index wins.
        mask = '0;
        for (int i = 0; i < NUM_M; i++) begin
            mask[i] = (mode == ARB_FIXED) || (i > int'(ptr));
        end
        dbl = {req, req & mask};

        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < 2 * NUM_M; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end

        win     = '0;
        win_idx = '0;
        if (found) begin
            if (pos >= NUM_M) pos = pos - NUM_M;
            win     = NUM_M'(1) << pos;
            win_idx = IDX_W'(pos);
        end
    end

endmodule

// File: rtl/arb_lock_m2s.sv
// rtl/arb_lock_m2s.sv - N-master arbiter with grant locked until done
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   arbiter_type  ARB_RR / ARB_FIXED, sampled only on arbitration cycles
//   req           per-master level request
//   done          pulse closing the granted transaction
//   grant         registered one-hot grant
//   grant_vld     registered |grant
//   grant_idx     registered binary index of grant (0 when idle)
module arb_lock_m2s
    import axi_ic_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int IDX_W = clog2(NUM_M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arbiter_type,
    input  logic [NUM_M-1:0] req,
    input  logic             done,
    output logic [NUM_M-1:0] grant,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx
);

    arb_state_e       state, state_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [NUM_M-1:0] grant_n;
    logic [NUM_M-1:0] win;
    logic [IDX_W-1:0] win_idx;

    arb_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .mode    (arbiter_type),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant;
        case (state)
            ST_IDLE: begin
                grant_n = '0;
                if (|req) begin
                    grant_n  = win;
                    rr_ptr_n = win_idx;
                    state_n  = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // Re-arbitrate on the done cycle itself so back-to-back
                // transactions see no idle bubble.
                if (done) begin
                    if (|req) begin
                        grant_n  = win;
                        rr_ptr_n = win_idx;
                    end else begin
                        grant_n = '0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_M - 1);
            grant     <= '0;
            grant_vld <= 1'b0;
            grant_idx <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant     <= grant_n;
            grant_vld <= |grant_n;
            grant_idx <= IDX_W'(onehot2bin(32'(grant_n)));
        end
    end

endmodule

// File: tb/tb_arb_lock_m2s.sv
// tb/tb_arb_lock_m2s.sv - scoreboard bench for arb_lock_m2s (NUM_M=3 and NUM_M=5)
module tb_arb_lock_m2s;

    typedef struct {
        logic [7:0] g;
        logic       v;
        logic [7:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arb_type = 1'b0;
    logic [2:0] req3 = '0;
    logic       done3 = 1'b0;
    logic [4:0] req5 = '0;
    logic       done5 = 1'b0;
    logic [2:0] g3;
    logic       v3;
    logic [1:0] i3;
    logic [4:0] g5;
    logic       v5;
    logic [2:0] i5;

    exp_t q3[$];
    exp_t q5[$];
    int   checks = 0;
    int   errors = 0;
    int   own3 = -1, last3 = 2;
    int   own5 = -1, last5 = 4;

    always #5 clk = ~clk;

    arb_lock_m2s #(.NUM_M(3)) dut3 (
        .clk (clk), .rst_n (rst_n), .arbiter_type (arb_type), .req (req3),
        .done (done3), .grant (g3), .grant_vld (v3), .grant_idx (i3)
    );

    arb_lock_m2s #(.NUM_M(5)) dut5 (
        .clk (clk), .rst_n (rst_n), .arbiter_type (arb_type), .req (req5),
        .done (done5), .grant (g5), .grant_vld (v5), .grant_idx (i5)
    );

    // Winner straight from the arbitration rules; -1 when nobody requests.
    function automatic int model_arb(input int n, input logic [7:0] r, input int last,
                                     input logic fixed);
        if (fixed) begin
            for (int j = 0; j < n; j++) if (r[j]) return j;
        end else begin
            for (int k = 1; k <= n; k++) if (r[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int n, input logic [7:0] r, input logic d, input logic t,
                              input logic rn, inout int own, inout int last, output exp_t e);
        int w;
        if (!rn) begin
            own  = -1;
            last = n - 1;
        end else if (own < 0 || d) begin
            w = model_arb(n, r, last, t);
            own = w;
            if (w >= 0) last = w;
        end
        e.g   = (own >= 0) ? (8'd1 << own) : 8'd0;
        e.v   = (own >= 0);
        e.idx = (own >= 0) ? 8'(own) : 8'd0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] r3, input logic d3, input logic [4:0] r5,
                        input logic d5, input logic t, input logic rn);
        exp_t e;
        @(negedge clk);
        req3 = r3; done3 = d3; req5 = r5; done5 = d5; arb_type = t; rst_n = rn;
        model_step(3, {5'b0, r3}, d3, t, rn, own3, last3, e);
        q3.push_back(e);
        model_step(5, {3'b0, r5}, d5, t, rn, own5, last5, e);
        q5.push_back(e);
    endtask

    // Short form: the 5-master instance sees a scrambled copy of the 3-master stimulus.
    task automatic s3(input logic [2:0] r3, input logic d, input logic t, input logic rn = 1'b1);
        step(r3, d, {r3[1:0], r3}, d, t, rn);
    endtask

    // Monitor: outputs are registered and always present, so pop every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("grant3", {5'b0, g3}, e.g);
                check("grant_vld3", {7'b0, v3}, {7'b0, e.v});
                check("grant_idx3", {6'b0, i3}, e.idx);
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                check("grant5", {3'b0, g5}, e.g);
                check("grant_vld5", {7'b0, v5}, {7'b0, e.v});
                check("grant_idx5", {5'b0, i5}, e.idx);
            end
        end
    end

    initial begin
        // Reset
        s3(3'b000, 0, 0, 0);
        s3(3'b000, 0, 0, 0);
        // RR with all requesting: 001, 010, 100, 001 with no bubbles
        s3(3'b111, 0, 0);
        s3(3'b111, 1, 0);
        s3(3'b111, 1, 0);
        s3(3'b111, 1, 0);
        s3(3'b000, 1, 0);
        // Fixed: 110 -> 010, master 0 joins mid-lock, done -> 001
        s3(3'b110, 0, 1);
        s3(3'b111, 0, 1);
        s3(3'b111, 0, 1);
        s3(3'b111, 1, 1);
        s3(3'b000, 1, 1);
        // Lock hold with req dropped, then release
        s3(3'b100, 0, 1);
        for (int i = 0; i < 5; i++) s3(3'b000, 0, 1);
        s3(3'b000, 1, 1);
        s3(3'b000, 0, 1);
        // RR wrap from last winner 2
        s3(3'b100, 0, 0);
        s3(3'b101, 1, 0);
        s3(3'b000, 1, 0);
        // Mode switch mid-lock
        s3(3'b010, 0, 0);
        s3(3'b010, 0, 1);
        s3(3'b101, 1, 1);
        s3(3'b000, 1, 0);
        // Reset mid-lock, then RR restarts at master 0
        s3(3'b010, 0, 0);
        s3(3'b010, 0, 0);
        s3(3'b010, 0, 0, 0);
        s3(3'b111, 0, 0);
        s3(3'b111, 1, 0);
        // done in IDLE ignored
        s3(3'b000, 1, 0);
        s3(3'b000, 1, 0);
        // 5-master high index reach
        step(3'b000, 0, 5'b10000, 0, 0, 1);
        step(3'b000, 0, 5'b11000, 1, 0, 1);
        step(3'b000, 0, 5'b00000, 1, 0, 1);
        // Randomized traffic
        begin
            logic t;
            t = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 9) == 0) t = ~t;
                step(3'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom),
                     ($urandom_range(0, 2) == 0), t, ($urandom_range(0, 60) != 0));
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q3.size() != 0 || q5.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q3.size(), q5.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
